// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: datapath widths, the packed control
// bundle layout used between decode and execute, and ALUOp encodings.
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int CTRL_W = 9;

   // Control bundle layout: {RegWrite,MemRead,MemWrite,MemToReg,ALUSrc,RegDst,Branch,ALUOp[1:0]}
   localparam int CTRL_REGWRITE = 8;
   localparam int CTRL_MEMREAD  = 7;
   localparam int CTRL_MEMWRITE = 6;
   localparam int CTRL_MEMTOREG = 5;
   localparam int CTRL_ALUSRC   = 4;
   localparam int CTRL_REGDST   = 3;
   localparam int CTRL_BRANCH   = 2;
   localparam int CTRL_ALUOP_HI = 1;
   localparam int CTRL_ALUOP_LO = 0;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

   // What the ID/EX register does on the coming edge.
   typedef enum logic [1:0] {
      UPD_LOAD   = 2'd0,
      UPD_HOLD   = 2'd1,
      UPD_BUBBLE = 2'd2,
      UPD_FLUSH  = 2'd3
   } upd_e;

   function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
      return ctrl[CTRL_MEMREAD];
   endfunction

endpackage

// File: rtl/wb_bypass_mux.sv
// Forwards a same-cycle write-back value in place of the register-file read,
// so an operand decoded while its producer writes back is never stale.
module wb_bypass_mux #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] src_reg_i,
   input  logic [DATA_W-1:0] rf_data_i,
   input  logic              wb_we_i,
   input  logic [REG_AW-1:0] wb_reg_i,
   input  logic [DATA_W-1:0] wb_data_i,
   output logic [DATA_W-1:0] operand_o
);

   logic hit;

   // $zero is hardwired, so a write-back aimed at it must not leak through.
   assign hit       = wb_we_i && (wb_reg_i != '0) && (wb_reg_i == src_reg_i);
   assign operand_o = hit ? wb_data_i : rf_data_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands (with write-back bypass),
// fields and control, and raises a combinational load-use stall request.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CTRL_W = 9
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Id_valid,
   input  logic [CTRL_W-1:0] Id_ctrl,
   input  logic [REG_AW-1:0] Id_rs,
   input  logic [REG_AW-1:0] Id_rt,
   input  logic [REG_AW-1:0] Id_rd,
   input  logic [DATA_W-1:0] Id_imm,
   input  logic [DATA_W-1:0] Id_pc4,
   input  logic [DATA_W-1:0] Read_data1,
   input  logic [DATA_W-1:0] Read_data2,
   input  logic              Wb_reg_write,
   input  logic [REG_AW-1:0] Wb_write_reg,
   input  logic [DATA_W-1:0] Wb_write_data,
   input  logic              Stall,
   input  logic              Flush,
   output logic              Ex_valid,
   output logic [CTRL_W-1:0] Ex_ctrl,
   output logic [REG_AW-1:0] Ex_rs,
   output logic [REG_AW-1:0] Ex_rt,
   output logic [REG_AW-1:0] Ex_rd,
   output logic [DATA_W-1:0] Ex_a,
   output logic [DATA_W-1:0] Ex_b,
   output logic [DATA_W-1:0] Ex_imm,
   output logic [DATA_W-1:0] Ex_pc4,
   output logic              Hazard_stall
);

   import mips_pkg::*;

   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
   logic [REG_AW-1:0] rs_q,    rs_d;
   logic [REG_AW-1:0] rt_q,    rt_d;
   logic [REG_AW-1:0] rd_q,    rd_d;
   logic [DATA_W-1:0] a_q,     a_d;
   logic [DATA_W-1:0] b_q,     b_d;
   logic [DATA_W-1:0] imm_q,   imm_d;
   logic [DATA_W-1:0] pc4_q,   pc4_d;

   logic [REG_AW-1:0] src_reg [2];
   logic [DATA_W-1:0] rf_data [2];
   logic [DATA_W-1:0] operand [2];

   logic hazard;
   upd_e upd;

   assign src_reg[0] = Id_rs;
   assign src_reg[1] = Id_rt;
   assign rf_data[0] = Read_data1;
   assign rf_data[1] = Read_data2;

   for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
      wb_bypass_mux #(
         .DATA_W (DATA_W),
         .REG_AW (REG_AW)
      ) u_bypass (
         .src_reg_i (src_reg[gi]),
         .rf_data_i (rf_data[gi]),
         .wb_we_i   (Wb_reg_write),
         .wb_reg_i  (Wb_write_reg),
         .wb_data_i (Wb_write_data),
         .operand_o (operand[gi])
      );
   end

   // Load in EX whose destination feeds the instruction now in decode.
   assign hazard = !Rst && valid_q && ctrl_is_load(CTRL_W'(ctrl_q)) && Id_valid
                   && (rt_q != '0) && ((rt_q == Id_rs) || (rt_q == Id_rt));
   assign Hazard_stall = hazard;

   always_comb begin
      if (Flush) begin
         upd = UPD_FLUSH;
      end else if (Stall) begin
         upd = UPD_HOLD;
      end else if (hazard) begin
         upd = UPD_BUBBLE;
      end else begin
         upd = UPD_LOAD;
      end
   end

   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      rd_d    = rd_q;
      a_d     = a_q;
      b_d     = b_q;
      imm_d   = imm_q;
      pc4_d   = pc4_q;

      // Data fields are don't-care under a bubble, so they load whenever not held.
      if (upd != UPD_HOLD) begin
         rs_d  = Id_rs;
         rt_d  = Id_rt;
         rd_d  = Id_rd;
         a_d   = operand[0];
         b_d   = operand[1];
         imm_d = Id_imm;
         pc4_d = Id_pc4;
      end

      case (upd)
         UPD_LOAD: begin
            valid_d = Id_valid;
            ctrl_d  = Id_valid ? Id_ctrl : CTRL_W'(NOP_CTRL);
         end
         UPD_BUBBLE, UPD_FLUSH: begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_W'(NOP_CTRL);
         end
         default: begin
            valid_d = valid_q;
            ctrl_d  = ctrl_q;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         pc4_q   <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rd_q    <= rd_d;
         a_q     <= a_d;
         b_q     <= b_d;
         imm_q   <= imm_d;
         pc4_q   <= pc4_d;
      end
   end

   assign Ex_valid = valid_q;
   assign Ex_ctrl  = ctrl_q;
   assign Ex_rs    = rs_q;
   assign Ex_rt    = rt_q;
   assign Ex_rd    = rd_q;
   assign Ex_a     = a_q;
   assign Ex_b     = b_q;
   assign Ex_imm   = imm_q;
   assign Ex_pc4   = pc4_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a reference model pushes the expected EX
// contents into a queue at drive time; they are popped and checked after the edge.
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid;
      logic [8:0]  ctrl;
      logic [4:0]  rs, rt, rd;
      logic [31:0] a, b, imm, pc4;
   } ex_t;

   localparam logic [8:0] CTRL_LW  = 9'h1B0;  // RegWrite,MemRead,MemToReg,ALUSrc
   localparam logic [8:0] CTRL_R   = 9'h10A;  // RegWrite,RegDst,ALUOp=10
   localparam logic [8:0] CTRL_SW  = 9'h050;  // MemWrite,ALUSrc

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Id_valid;
   logic [8:0]  Id_ctrl;
   logic [4:0]  Id_rs, Id_rt, Id_rd;
   logic [31:0] Id_imm, Id_pc4, Read_data1, Read_data2;
   logic        Wb_reg_write;
   logic [4:0]  Wb_write_reg;
   logic [31:0] Wb_write_data;
   logic        Stall, Flush;
   logic        Ex_valid;
   logic [8:0]  Ex_ctrl;
   logic [4:0]  Ex_rs, Ex_rt, Ex_rd;
   logic [31:0] Ex_a, Ex_b, Ex_imm, Ex_pc4;
   logic        Hazard_stall;

   int   total = 0;
   int   bad   = 0;
   ex_t  m;
   ex_t  exp_q[$];
   logic [31:0] pc = 32'h0000_1000;

   always #5 Clk = ~Clk;

   id_ex_stage dut (
      .Clk (Clk), .Rst (Rst), .Id_valid (Id_valid), .Id_ctrl (Id_ctrl),
      .Id_rs (Id_rs), .Id_rt (Id_rt), .Id_rd (Id_rd), .Id_imm (Id_imm), .Id_pc4 (Id_pc4),
      .Read_data1 (Read_data1), .Read_data2 (Read_data2),
      .Wb_reg_write (Wb_reg_write), .Wb_write_reg (Wb_write_reg), .Wb_write_data (Wb_write_data),
      .Stall (Stall), .Flush (Flush),
      .Ex_valid (Ex_valid), .Ex_ctrl (Ex_ctrl), .Ex_rs (Ex_rs), .Ex_rt (Ex_rt), .Ex_rd (Ex_rd),
      .Ex_a (Ex_a), .Ex_b (Ex_b), .Ex_imm (Ex_imm), .Ex_pc4 (Ex_pc4),
      .Hazard_stall (Hazard_stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %08h expected %08h", tag, obs, expv);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".valid"}, 32'(Ex_valid), 32'd0);
      chk({tag, ".ctrl"},  32'(Ex_ctrl),  32'd0);
      chk({tag, ".regs"},  32'({Ex_rs, Ex_rt, Ex_rd}), 32'd0);
      chk({tag, ".a"},     Ex_a,   32'd0);
      chk({tag, ".b"},     Ex_b,   32'd0);
      chk({tag, ".imm"},   Ex_imm, 32'd0);
      chk({tag, ".pc4"},   Ex_pc4, 32'd0);
      chk({tag, ".haz"},   32'(Hazard_stall), 32'd0);
   endtask

   // Drive one decode slot, check the stall request, predict EX, clock, compare.
   task automatic step(input string tag, input logic v, input logic [8:0] c,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd,
                       input logic st, input logic fl);
      ex_t  e;
      ex_t  got;
      logic haz;
      Id_valid = v; Id_ctrl = c; Id_rs = rs; Id_rt = rt; Id_rd = rd;
      Id_imm = $urandom; Id_pc4 = pc; pc = pc + 32'd4;
      Read_data1 = rd1; Read_data2 = rd2;
      Wb_reg_write = wbw; Wb_write_reg = wbr; Wb_write_data = wbd;
      Stall = st; Flush = fl;
      #1;
      haz = m.valid && m.ctrl[7] && v && (m.rt != 5'd0) && (m.rt == rs || m.rt == rt);
      chk({tag, ".hazard"}, 32'(Hazard_stall), 32'(haz));
      e.rs = rs; e.rt = rt; e.rd = rd; e.imm = Id_imm; e.pc4 = Id_pc4;
      e.a = (wbw && wbr != 5'd0 && wbr == rs) ? wbd : rd1;
      e.b = (wbw && wbr != 5'd0 && wbr == rt) ? wbd : rd2;
      if (fl || (!st && haz)) begin
         e.valid = 1'b0; e.ctrl = 9'd0;
      end else if (st) begin
         e = m;
      end else begin
         e.valid = v; e.ctrl = v ? c : 9'd0;
      end
      exp_q.push_back(e);
      m = e;
      @(posedge Clk);
      #1;
      e = exp_q.pop_front();
      got = '{Ex_valid, Ex_ctrl, Ex_rs, Ex_rt, Ex_rd, Ex_a, Ex_b, Ex_imm, Ex_pc4};
      $display("step %s: haz=%0b valid=%0b ctrl=%03h a=%08h b=%08h",
               tag, haz, Ex_valid, Ex_ctrl, Ex_a, Ex_b);
      chk({tag, ".valid"}, 32'(got.valid), 32'(e.valid));
      chk({tag, ".ctrl"},  32'(got.ctrl),  32'(e.ctrl));
      if (e.valid) begin
         chk({tag, ".regs"}, 32'({got.rs, got.rt, got.rd}), 32'({e.rs, e.rt, e.rd}));
         chk({tag, ".a"},    got.a,   e.a);
         chk({tag, ".b"},    got.b,   e.b);
         chk({tag, ".imm"},  got.imm, e.imm);
         chk({tag, ".pc4"},  got.pc4, e.pc4);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst = 1'b1; Id_valid = 0; Id_ctrl = 0; Id_rs = 0; Id_rt = 0; Id_rd = 0;
      Id_imm = 0; Id_pc4 = 0; Read_data1 = 0; Read_data2 = 0;
      Wb_reg_write = 0; Wb_write_reg = 0; Wb_write_data = 0; Stall = 0; Flush = 0;
      m = '0;
      repeat (2) @(posedge Clk);
      #1;
      chk_zero("reset");
      @(negedge Clk);
      Rst = 1'b0;

      // Write-back bypass on each operand, and register 0 never bypassed.
      step("byp_a", 1, CTRL_R, 5'd3, 5'd4, 5'd6, 32'h11, 32'h44, 1, 5'd3, 32'hABCD, 0, 0);
      step("byp_zero", 1, CTRL_R, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 1, 5'd0, 32'hFFFF, 0, 0);
      step("byp_b", 1, CTRL_SW, 5'd2, 5'd7, 5'd0, 32'h22, 32'h77, 1, 5'd7, 32'h5A5A, 0, 0);
      step("no_wbw", 1, CTRL_R, 5'd9, 5'd9, 5'd1, 32'h99, 32'h98, 0, 5'd9, 32'hDEAD, 0, 0);

      // Load-use on rs: bubble, then the held instruction re-enters.
      step("lw5", 1, CTRL_LW, 5'd1, 5'd5, 5'd0, 32'h100, 32'h0, 0, 5'd0, 32'h0, 0, 0);
      step("use_rs", 1, CTRL_R, 5'd5, 5'd8, 5'd9, 32'h55, 32'h88, 0, 5'd0, 32'h0, 0, 0);
      step("reenter", 1, CTRL_R, 5'd5, 5'd8, 5'd9, 32'h55, 32'h88, 1, 5'd5, 32'hC0DE, 0, 0);
      // Load-use on rt, with an external stall that must win over the hazard.
      step("lw6", 1, CTRL_LW, 5'd1, 5'd6, 5'd0, 32'h200, 32'h0, 0, 5'd0, 32'h0, 0, 0);
      step("use_rt_st", 1, CTRL_R, 5'd2, 5'd6, 5'd3, 32'h12, 32'h66, 0, 5'd0, 32'h0, 1, 0);
      step("use_rt", 1, CTRL_R, 5'd2, 5'd6, 5'd3, 32'h12, 32'h66, 0, 5'd0, 32'h0, 0, 0);
      // No hazard: lw into $zero, and an invalid decode slot behind a load.
      step("lw0", 1, CTRL_LW, 5'd1, 5'd0, 5'd0, 32'h300, 32'h0, 0, 5'd0, 32'h0, 0, 0);
      step("use_r0", 1, CTRL_R, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
      step("lw7", 1, CTRL_LW, 5'd1, 5'd7, 5'd0, 32'h400, 32'h0, 0, 5'd0, 32'h0, 0, 0);
      step("idle", 0, CTRL_R, 5'd7, 5'd7, 5'd7, 32'h1, 32'h2, 0, 5'd0, 32'h0, 0, 0);

      // Stall+Flush together: flush wins. Then stall alone holds 0x22.
      step("a22", 1, CTRL_R, 5'd10, 5'd11, 5'd12, 32'h22, 32'h33, 0, 5'd0, 32'h0, 0, 0);
      step("st_fl", 1, CTRL_R, 5'd13, 5'd14, 5'd15, 32'h44, 32'h55, 0, 5'd0, 32'h0, 1, 1);
      step("a22b", 1, CTRL_R, 5'd10, 5'd11, 5'd12, 32'h22, 32'h33, 0, 5'd0, 32'h0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step($sformatf("stall%0d", i), 1, CTRL_SW, 5'd16, 5'd17, 5'd18,
              32'h99 + 32'(i), 32'h77, 1, 5'd16, 32'hBEEF, 1, 0);
      end
      step("flush", 1, CTRL_R, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 0, 5'd0, 32'h0, 0, 1);

      // Back-to-back valid instructions without loads: no gaps.
      for (int i = 0; i < 8; i++) begin
         logic [8:0] c;
         c = 9'($urandom) & ~9'h080;
         step($sformatf("b2b%0d", i), 1, c, 5'($urandom), 5'($urandom), 5'($urandom),
              $urandom, $urandom, 1'($urandom), 5'($urandom_range(0, 3)), $urandom, 0, 0);
      end

      // Reset pulse mid-run clears everything before the next edge.
      step("pre_rst", 1, CTRL_LW, 5'd1, 5'd9, 5'd2, 32'h1234, 32'h5678, 0, 5'd0, 32'h0, 0, 0);
      Id_valid = 1; Id_rs = 5'd9;
      #2;
      Rst = 1'b1;
      #1;
      chk_zero("mid_rst");
      m = '0;
      @(negedge Clk);
      Rst = 1'b0;
      step("post_rst", 1, CTRL_R, 5'd9, 5'd3, 5'd4, 32'hAA, 32'hBB, 0, 5'd0, 32'h0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
